// File: rtl/lane_fifo_pkg.sv
// Shared types and sizing helpers for the lane FIFO: entry type, pointer/count
// widths and the lane bit-slice helper used by storage and the top level.
package lane_fifo_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_PARALLELISM = 1;
  localparam int DEF_HEIGHT      = 128;

  // Entry shape at the default sizing; parameterised instances build the
  // equivalent signed vector from their own WIDTH and PARALLELISM.
  typedef logic signed [DEF_PARALLELISM*DEF_WIDTH-1:0] entry_t;

  function automatic int ptr_width(input int height);
    return $clog2(height);
  endfunction

  // One extra bit so that a completely full FIFO (count == HEIGHT) is representable.
  function automatic int count_width(input int height);
    return $clog2(height) + 1;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/fifo_memory.sv
// Lane-organised storage for lane_fifo: one write port with a 1-cycle write,
// one combinational read port.
module fifo_memory
  import lane_fifo_pkg::*;
#(
  parameter  int WIDTH       = DEF_WIDTH,
  parameter  int PARALLELISM = DEF_PARALLELISM,
  parameter  int HEIGHT      = DEF_HEIGHT,
  localparam int AW          = ptr_width(HEIGHT),
  localparam int DW          = PARALLELISM * WIDTH
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [DW-1:0] wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [DW-1:0] rd_data
);

  for (genvar k = 0; k < PARALLELISM; k++) begin : g_lane
    logic signed [WIDTH-1:0] mem [HEIGHT];

    // NOTE: storage has no reset; the pointers alone define which entries are
    // valid, and leaving the array unreset lets it map onto RAM primitives.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data[lane_lsb(k, WIDTH) +: WIDTH];
      end
    end

    assign rd_data[lane_lsb(k, WIDTH) +: WIDTH] = mem[rd_addr];
  end

endmodule

// File: rtl/lane_fifo.sv
// Single-clock FIFO of PARALLELISM signed lanes per entry, with occupancy flags
// and sticky overflow/underflow error flags. Storage lives in fifo_memory.
module lane_fifo
  import lane_fifo_pkg::*;
#(
  parameter  int WIDTH       = DEF_WIDTH,
  parameter  int PARALLELISM = DEF_PARALLELISM,
  parameter  int HEIGHT      = DEF_HEIGHT,
  parameter  int AF_THRESH   = HEIGHT - 2,
  localparam int AW          = ptr_width(HEIGHT),
  localparam int CW          = count_width(HEIGHT),
  localparam int DW          = PARALLELISM * WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 overflow,
  output logic                 underflow
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push, pop, wr_en;

  // Flags come only from registered count, so in_ready never depends on out_ready.
  assign full        = (count_q == CW'(HEIGHT));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CW'(AF_THRESH));
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  assign push  = in_valid && in_ready;
  assign pop   = out_valid && out_ready;
  assign wr_en = push && !flush && !rst;

  // NOTE: every signal gets its hold value first so no path through the
  // if/case tree can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  || (in_valid && full);
    underflow_d = underflow_q || (out_ready && empty);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_memory #(
    .WIDTH       (WIDTH),
    .PARALLELISM (PARALLELISM),
    .HEIGHT      (HEIGHT)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_addr (rd_ptr_q),
    .rd_data (out_data)
  );

endmodule

// File: tb/tb_lane_fifo.sv
// Directed bench for lane_fifo (WIDTH=8, PARALLELISM=2, HEIGHT=4, AF_THRESH=3):
// stimulus queues expected pops; a negedge monitor compares every DUT pop.
module tb_lane_fifo;

  localparam int WIDTH       = 8;
  localparam int PARALLELISM = 2;
  localparam int HEIGHT      = 4;
  localparam int AF_THRESH   = 3;
  localparam int DW          = WIDTH * PARALLELISM;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic [2:0]           count;
  logic                 full, empty, almost_full, overflow, underflow;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [DW-1:0] exp_q [$];

  lane_fifo #(
    .WIDTH       (WIDTH),
    .PARALLELISM (PARALLELISM),
    .HEIGHT      (HEIGHT),
    .AF_THRESH   (AF_THRESH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pops are committed on the next rising edge; data is compared here while stable.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h, expected no pop", out_data);
      end else begin
        logic [DW-1:0] exp;
        exp = exp_q.pop_front();
        check("pop_data", $unsigned(out_data), 32'(exp));
      end
    end
  end

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},     32'(count),       32'd0);
    check({tag, "_empty"},     32'(empty),       32'd1);
    check({tag, "_full"},      32'(full),        32'd0);
    check({tag, "_af"},        32'(almost_full), 32'd0);
    check({tag, "_overflow"},  32'(overflow),    32'd0);
    check({tag, "_underflow"}, 32'(underflow),   32'd0);
    check({tag, "_in_ready"},  32'(in_ready),    32'd1);
    check({tag, "_out_valid"}, 32'(out_valid),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] fill_data [4];

    rst   = 1'b1;
    flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    check_reset_state("reset");

    // Fill to full, watching count and the occupancy flags climb.
    fill_data = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill_data[i], 1'b0);
      exp_q.push_back(fill_data[i]);
      tick();
      check("fill_count",    32'(count),       32'(i + 1));
      check("fill_af",       32'(almost_full), 32'(i + 1 >= 3));
      check("fill_full",     32'(full),        32'(i + 1 == 4));
      check("fill_in_ready", 32'(in_ready),    32'(i + 1 != 4));
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1);
      tick();
      check("drain_count", 32'(count), 32'(3 - i));
    end
    drive(1'b0, '0, 1'b0);
    check("drain_empty",     32'(empty),     32'd1);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // Full with push and pop offered together: pop happens, push is refused.
    fill_data = '{16'h1011, 16'h1213, 16'h1415, 16'h1617};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill_data[i], 1'b0);
      exp_q.push_back(fill_data[i]);
      tick();
    end
    check("ovf_pre_full", 32'(full), 32'd1);
    drive(1'b1, 16'h1111, 1'b1);
    tick();
    check("ovf_count",    32'(count),    32'd3);
    check("ovf_flag",     32'(overflow), 32'd1);
    check("ovf_in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 16'h1818, 1'b0);
    exp_q.push_back(16'h1818);
    tick();
    check("ovf_retry_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    check("ovf_drain_empty", 32'(empty),    32'd1);
    check("ovf_sticky",      32'(overflow), 32'd1);
    do_reset();
    check("ovf_rst_clear", 32'(overflow), 32'd0);

    // Streaming through ten entries wraps both pointers twice.
    drive(1'b1, 16'h0000, 1'b0);
    exp_q.push_back(16'h0000);
    tick();
    check("stream_count_0", 32'(count), 32'd1);
    for (int i = 1; i < 10; i++) begin
      drive(1'b1, {8'(i), 8'(i)}, 1'b1);
      exp_q.push_back({8'(i), 8'(i)});
      tick();
      check("stream_count", 32'(count), 32'd1);
    end
    drive(1'b0, '0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    check("stream_end_empty", 32'(empty),     32'd1);
    check("stream_underflow", 32'(underflow), 32'd0);
    check("stream_overflow",  32'(overflow),  32'd0);

    // Pop request while empty: sticky underflow survives flush, not rst.
    drive(1'b0, '0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    check("unf_flag",  32'(underflow), 32'd1);
    check("unf_count", 32'(count),     32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("unf_after_flush", 32'(underflow), 32'd1);
    do_reset();
    check("unf_after_rst", 32'(underflow), 32'd0);

    // Flush with a push in the same cycle discards everything, including the push.
    fill_data = '{16'h2122, 16'h2324, 16'h2526, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, fill_data[i], 1'b0);
      exp_q.push_back(fill_data[i]);
      tick();
    end
    check("flush_pre_count", 32'(count), 32'd3);
    flush = 1'b1;
    drive(1'b1, 16'h7777, 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    exp_q.delete();
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    drive(1'b1, 16'h0909, 1'b0);
    exp_q.push_back(16'h0909);
    tick();
    check("flush_next_head", 32'($unsigned(out_data)), 32'h0909);
    drive(1'b0, '0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);

    // Reset in the middle of streaming discards the in-flight push and pop.
    drive(1'b1, 16'h0000, 1'b0);
    exp_q.push_back(16'h0000);
    tick();
    for (int i = 1; i < 5; i++) begin
      drive(1'b1, {8'(i), 8'(i)}, 1'b1);
      exp_q.push_back({8'(i), 8'(i)});
      tick();
    end
    rst = 1'b1;
    drive(1'b1, 16'h0505, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    exp_q.delete();
    check_reset_state("midrst");
    drive(1'b1, 16'h5A5A, 1'b0);
    exp_q.push_back(16'h5A5A);
    tick();
    check("midrst_head",      32'($unsigned(out_data)), 32'h5A5A);
    check("midrst_out_valid", 32'(out_valid),           32'd1);
    check("midrst_count",     32'(count),               32'd1);
    drive(1'b0, '0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    check("midrst_end_empty", 32'(empty), 32'd1);

    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
